// File: rtl/game_button_conditioner_if.sv
// Button-side bundle: raw push-button inputs plus the conditioned pulse and level outputs.
// The master drives the raw buttons; the slave is the conditioner.
interface game_button_conditioner_if;
    logic raw_higher;
    logic raw_lower;
    logic btn_higher;
    logic btn_lower;
    logic deb_higher;
    logic deb_lower;

    modport master (
        output raw_higher,
        output raw_lower,
        input  btn_higher,
        input  btn_lower,
        input  deb_higher,
        input  deb_lower
    );

    modport slave (
        input  raw_higher,
        input  raw_lower,
        output btn_higher,
        output btn_lower,
        output deb_higher,
        output deb_lower
    );
endinterface

// File: rtl/game_button_conditioner.sv
// Two raw buttons -> 2-FF sync -> counter debounce -> one-shot, mutually exclusive action pulses.
// Latency: deb/btn update DEBOUNCE_CYCLES+1 edges after the first edge that samples a stable level; no backpressure.
module game_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int CNT_W           = 18
) (
    input  logic                        clk,
    input  logic                        rst_n,
    game_button_conditioner_if.slave    btn_if
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Channel index 0 is "higher", index 1 is "lower".
    logic [1:0]       raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       rise;
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_d;
    state_t           state_q;
    state_t           state_d;

    assign raw = {btn_if.raw_lower, btn_if.raw_higher};

    // Counter only runs while the synced level disagrees with the accepted one,
    // so any return to the old level restarts the count and it never wraps.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign rise = deb_d & ~deb_q;

    always_comb begin
        state_d = state_q;
        pulse_d = 2'b00;
        case (state_q)
            ARMED: begin
                if (rise == 2'b01 || rise == 2'b10) begin
                    pulse_d = rise;
                    state_d = LOCKED;
                end else if (rise == 2'b11) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Re-arm only once both buttons are seen released.
                if (deb_q == 2'b00) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            deb_q   <= 2'b00;
            pulse_q <= 2'b00;
            state_q <= ARMED;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_if.btn_higher = pulse_q[0];
    assign btn_if.btn_lower  = pulse_q[1];
    assign btn_if.deb_higher = deb_q[0];
    assign btn_if.deb_lower  = deb_q[1];

endmodule

// File: tb/tb_game_button_conditioner.sv
// Directed bench for game_button_conditioner with DEBOUNCE_CYCLES=4.
// Edge index 0 is the first edge sampling a new raw level; deb/btn are expected on index 5.
module tb_game_button_conditioner;

    localparam int N   = 4;
    localparam int LAT = N + 1;

    logic clk;
    logic rst_n;

    game_button_conditioner_if bif ();

    game_button_conditioner #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_if (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    int edge_no;
    int h_pulses;
    int l_pulses;
    int h_edge;
    int l_edge;
    int l_deb_seen;
    int overlap = 0;

    task automatic check(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        edge_no    = 0;
        h_pulses   = 0;
        l_pulses   = 0;
        h_edge     = -1;
        l_edge     = -1;
        l_deb_seen = 0;
    endtask

    // Advance n edges, sampling 1 time unit after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bif.btn_higher) begin
                h_pulses++;
                h_edge = edge_no;
            end
            if (bif.btn_lower) begin
                l_pulses++;
                l_edge = edge_no;
            end
            if (bif.deb_lower) l_deb_seen++;
            if (bif.btn_higher && bif.btn_lower) overlap++;
            edge_no++;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bif.raw_higher = 1'b0;
        bif.raw_lower  = 1'b0;
        clear_mon();
        tick(2);
        check("rst_btn_higher", int'(bif.btn_higher), 0);
        check("rst_btn_lower",  int'(bif.btn_lower),  0);
        check("rst_deb_higher", int'(bif.deb_higher), 0);
        check("rst_deb_lower",  int'(bif.deb_lower),  0);
        rst_n = 1'b1;
        tick(2);

        // 1: single clean press of higher
        clear_mon();
        bif.raw_higher = 1'b1;
        tick(12);
        check("t1_h_pulses",   h_pulses, 1);
        check("t1_h_edge",     h_edge,   LAT);
        check("t1_l_pulses",   l_pulses, 0);
        check("t1_deb_higher", int'(bif.deb_higher), 1);
        clear_mon();
        bif.raw_higher = 1'b0;
        tick(10);
        check("t1_release_pulses", h_pulses + l_pulses, 0);
        check("t1_release_deb",    int'(bif.deb_higher), 0);

        // 2: lower held only 3 cycles, one short of the debounce window
        clear_mon();
        bif.raw_lower = 1'b1;
        tick(3);
        bif.raw_lower = 1'b0;
        tick(10);
        check("t2_l_pulses",  l_pulses,   0);
        check("t2_deb_lower", l_deb_seen, 0);

        // 3: bounce 1,0,1,0 then stable 1 first sampled on edge 4
        clear_mon();
        bif.raw_higher = 1'b1; tick(1);
        bif.raw_higher = 1'b0; tick(1);
        bif.raw_higher = 1'b1; tick(1);
        bif.raw_higher = 1'b0; tick(1);
        bif.raw_higher = 1'b1;
        tick(12);
        check("t3_h_pulses", h_pulses, 1);
        check("t3_h_edge",   h_edge,   4 + LAT);
        check("t3_l_pulses", l_pulses, 0);
        bif.raw_higher = 1'b0;
        tick(10);

        // 4: simultaneous press gives nothing; lower works after release
        clear_mon();
        bif.raw_higher = 1'b1;
        bif.raw_lower  = 1'b1;
        tick(12);
        check("t4_both_pulses", h_pulses + l_pulses, 0);
        check("t4_deb_both",    int'({bif.deb_higher, bif.deb_lower}), 3);
        bif.raw_higher = 1'b0;
        bif.raw_lower  = 1'b0;
        tick(8);
        clear_mon();
        bif.raw_lower = 1'b1;
        tick(12);
        check("t4_l_pulses", l_pulses, 1);
        check("t4_l_edge",   l_edge,   LAT);
        check("t4_h_pulses", h_pulses, 0);
        bif.raw_lower = 1'b0;
        tick(10);

        // 5: lower pressed while higher still held is ignored
        clear_mon();
        bif.raw_higher = 1'b1;
        tick(8);
        check("t5_h_pulses", h_pulses, 1);
        clear_mon();
        bif.raw_lower = 1'b1;
        tick(12);
        check("t5_l_ignored",  l_pulses, 0);
        check("t5_deb_lower",  int'(bif.deb_lower), 1);
        bif.raw_higher = 1'b0;
        bif.raw_lower  = 1'b0;
        tick(10);
        clear_mon();
        bif.raw_lower = 1'b1;
        tick(12);
        check("t5_l_pulses", l_pulses, 1);
        check("t5_l_edge",   l_edge,   LAT);
        bif.raw_lower = 1'b0;
        tick(10);

        // 6: reset while higher is accepted and lower is mid-count
        clear_mon();
        bif.raw_higher = 1'b1;
        tick(8);
        check("t6_pre_deb_higher", int'(bif.deb_higher), 1);
        bif.raw_lower = 1'b1;
        tick(3);
        rst_n         = 1'b0;
        bif.raw_lower = 1'b0;
        tick(1);
        check("t6_rst_btn_higher", int'(bif.btn_higher), 0);
        check("t6_rst_btn_lower",  int'(bif.btn_lower),  0);
        check("t6_rst_deb_higher", int'(bif.deb_higher), 0);
        check("t6_rst_deb_lower",  int'(bif.deb_lower),  0);
        rst_n = 1'b1;
        clear_mon();
        tick(12);
        check("t6_h_pulses", h_pulses, 1);
        check("t6_h_edge",   h_edge,   LAT);
        check("t6_l_pulses", l_pulses, 0);

        check("never_both_pulses", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
